// File: rtl/accum_pkg.sv
// Shared encodings for the accumulator/save-stack block.
package accum_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LOAD = 3'b001,
    OP_PUSH = 3'b010,
    OP_POP  = 3'b011,
    OP_SWAP = 3'b100,
    OP_CLR  = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    SEL_REG  = 2'b00,
    SEL_IMM  = 2'b01,
    SEL_ALU  = 2'b10,
    SEL_HOLD = 2'b11
  } sel_e;

endpackage

// File: rtl/accum_lifo.sv
// DEPTH-entry LIFO save stack. Storage is not reset; only count is.
// The caller asserts at most one of push/pop/swap per cycle. Requests that
// would overflow or underflow are ignored here as well, so the count can
// never leave the range 0..DEPTH.
module accum_lifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       swap,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    top_idx;
  logic [CW-1:0]    wr_idx;
  logic             do_push;
  logic             do_pop;
  logic             do_swap;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop  && !empty;
  assign do_swap = swap && !empty;
  assign top_idx = count - CW'(1);
  assign wr_idx  = do_push ? count : top_idx;

  // Read the top-of-stack entry; reads as zero while the stack is empty.
  always_comb begin
    top = '0;
    if (!empty) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == top_idx) top = mem[i];
      end
    end
  end

  // Storage write: push writes one above the top, swap overwrites the top.
  always_ff @(posedge clk) begin
    if (do_push || do_swap) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == wr_idx) mem[i] <= wdata;
      end
    end
  end

  // Occupancy counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (do_push) begin
      count <= count + CW'(1);
    end else if (do_pop) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/accum_stack.sv
// WIDTH-bit accumulator with a DEPTH-entry save stack and sticky error flag.
// dout feeds the ALU A-operand and the regfile write-back path.
//
// Op interface: op_valid qualifies op/sel_acc/imm/reg_in/alu_in for the
// current cycle only. There is no ready/stall; every valid op completes on
// the rising edge that samples it, and its result is visible after that edge.
module accum_stack
  import accum_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IMM_W = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       CLB,
  input  logic                       op_valid,
  input  logic [2:0]                 op,
  input  logic [1:0]                 sel_acc,
  input  logic [IMM_W-1:0]           imm,
  input  logic [WIDTH-1:0]           reg_in,
  input  logic [WIDTH-1:0]           alu_in,
  input  logic                       err_clr,
  output logic [WIDTH-1:0]           dout,
  output logic                       zero,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       err
);

  logic [WIDTH-1:0] dout_next;
  logic [WIDTH-1:0] top;
  logic             push;
  logic             pop;
  logic             swap;
  logic             err_new;

  accum_lifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_lifo (
    .clk   (clk),
    .rst   (CLB),
    .push  (push),
    .pop   (pop),
    .swap  (swap),
    .wdata (dout),
    .top   (top),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign zero = (dout == '0);

  // Decode the op: pick the next accumulator value, stack request and error.
  // Refused ops (overflow, underflow, illegal code) change nothing but err.
  always_comb begin
    dout_next = dout;
    push      = 1'b0;
    pop       = 1'b0;
    swap      = 1'b0;
    err_new   = 1'b0;
    if (op_valid) begin
      case (op)
        OP_NOP: ;
        OP_LOAD: begin
          case (sel_acc)
            SEL_REG:  dout_next = reg_in;
            SEL_IMM:  dout_next = WIDTH'(imm);
            SEL_ALU:  dout_next = alu_in;
            default:  dout_next = dout;
          endcase
        end
        OP_PUSH: begin
          if (full) err_new = 1'b1;
          else      push    = 1'b1;
        end
        OP_POP: begin
          if (empty) begin
            err_new = 1'b1;
          end else begin
            pop       = 1'b1;
            dout_next = top;
          end
        end
        OP_SWAP: begin
          if (empty) begin
            err_new = 1'b1;
          end else begin
            swap      = 1'b1;
            dout_next = top;
          end
        end
        OP_CLR:  dout_next = '0;
        default: err_new = 1'b1;
      endcase
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or posedge CLB) begin
    if (CLB) dout <= '0;
    else     dout <= dout_next;
  end

  // Sticky error: a new error in the same cycle beats err_clr.
  always_ff @(posedge clk or posedge CLB) begin
    if (CLB)          err <= 1'b0;
    else if (err_new) err <= 1'b1;
    else if (err_clr) err <= 1'b0;
  end

endmodule

// File: tb/tb_accum_stack.sv
// Bench for accum_stack (WIDTH=8, IMM_W=4, DEPTH=4): directed scenarios with
// literal expectations, then random ops, all checked every cycle against a
// queue-based reference model.
module tb_accum_stack;
  import accum_pkg::*;

  localparam int WIDTH = 8;
  localparam int IMM_W = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);
  localparam int EW    = WIDTH + CW + 4;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             clb = 1'b1;
  logic             op_valid = 1'b0;
  logic [2:0]       op = 3'b000;
  logic [1:0]       sel_acc = 2'b00;
  logic [IMM_W-1:0] imm = '0;
  logic [WIDTH-1:0] reg_in = '0;
  logic [WIDTH-1:0] alu_in = '0;
  logic             err_clr = 1'b0;
  logic [WIDTH-1:0] dout;
  logic             zero;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             err;

  always #5 clk = ~clk;

  accum_stack #(
    .WIDTH (WIDTH),
    .IMM_W (IMM_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .CLB      (clb),
    .op_valid (op_valid),
    .op       (op),
    .sel_acc  (sel_acc),
    .imm      (imm),
    .reg_in   (reg_in),
    .alu_in   (alu_in),
    .err_clr  (err_clr),
    .dout     (dout),
    .zero     (zero),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .err      (err)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [WIDTH-1:0] m_dout = '0;
  logic [WIDTH-1:0] m_stk[$];
  logic             m_err = 1'b0;
  logic [EW-1:0]    exp_q[$];

  function automatic logic [EW-1:0] pack_exp();
    logic [CW-1:0] c;
    c = CW'(m_stk.size());
    return {m_dout, c, m_err, (m_dout == '0), (m_stk.size() == 0), (m_stk.size() == DEPTH)};
  endfunction

  always @(posedge clk or posedge clb) begin
    logic bad;
    logic [WIDTH-1:0] t;
    if (clb) begin
      m_dout = '0;
      m_stk.delete();
      m_err = 1'b0;
    end else begin
      bad = 1'b0;
      if (op_valid) begin
        case (op)
          3'd0: ;
          3'd1: begin
            if (sel_acc == 2'd0)      m_dout = reg_in;
            else if (sel_acc == 2'd1) m_dout = {4'h0, imm};
            else if (sel_acc == 2'd2) m_dout = alu_in;
          end
          3'd2: if (m_stk.size() == DEPTH) bad = 1'b1; else m_stk.push_back(m_dout);
          3'd3: if (m_stk.size() == 0) bad = 1'b1; else m_dout = m_stk.pop_back();
          3'd4: begin
            if (m_stk.size() == 0) bad = 1'b1;
            else begin
              t = m_stk.pop_back();
              m_stk.push_back(m_dout);
              m_dout = t;
            end
          end
          3'd5: m_dout = '0;
          default: bad = 1'b1;
        endcase
      end
      if (bad)          m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
    end
    exp_q.delete();
    exp_q.push_back(pack_exp());
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q[$];
      exp_q.delete();
      chk("sb_dout",  32'(dout),  32'(e[EW-1 -: WIDTH]));
      chk("sb_count", 32'(count), 32'(e[CW+3:4]));
      chk("sb_err",   32'(err),   32'(e[3]));
      chk("sb_zero",  32'(zero),  32'(e[2]));
      chk("sb_empty", 32'(empty), 32'(e[1]));
      chk("sb_full",  32'(full),  32'(e[0]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_op(input logic v, input logic [2:0] o, input logic [1:0] s,
                       input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] a,
                       input logic [IMM_W-1:0] i, input logic ec);
    @(negedge clk);
    op_valid = v;
    op       = o;
    sel_acc  = s;
    reg_in   = r;
    alu_in   = a;
    imm      = i;
    err_clr  = ec;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    err_clr  = 1'b0;
  endtask

  task automatic simple(input logic [2:0] o);
    do_op(1'b1, o, 2'b00, '0, '0, '0, 1'b0);
  endtask

  task automatic load_reg(input logic [WIDTH-1:0] v);
    do_op(1'b1, OP_LOAD, SEL_REG, v, '0, '0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] pops[4];

  initial begin
    pops[0] = 8'h44; pops[1] = 8'h33; pops[2] = 8'h22; pops[3] = 8'h11;
    clb = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout",  32'(dout),  32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_err",   32'(err),   32'h0);
    chk("rst_flags", {29'b0, zero, empty, full}, 32'b110);
    @(negedge clk);
    clb = 1'b0;

    do_op(1'b1, OP_LOAD, SEL_IMM, '0, '0, 4'hA, 1'b0);
    chk("load_imm", 32'(dout), 32'h0A);
    chk("load_imm_model", 32'(m_dout), 32'h0A);
    chk("load_imm_zero", 32'(zero), 32'h0);
    do_op(1'b1, OP_LOAD, SEL_HOLD, 8'hFF, 8'hFF, 4'h5, 1'b0);
    chk("load_hold", 32'(dout), 32'h0A);
    chk("load_hold_err", 32'(err), 32'h0);

    for (int k = 1; k <= 4; k++) begin
      load_reg(8'(k * 8'h11));
      simple(OP_PUSH);
    end
    chk("push4_count", 32'(count), 32'd4);
    chk("push4_full", 32'(full), 32'd1);
    simple(OP_PUSH);
    chk("push_over_count", 32'(count), 32'd4);
    chk("push_over_err", 32'(err), 32'd1);
    chk("push_over_model", 32'(m_err), 32'd1);
    for (int k = 0; k < 4; k++) begin
      simple(OP_POP);
      chk("pop_dout", 32'(dout), 32'(pops[k]));
    end
    chk("pop_empty", 32'(empty), 32'd1);

    simple(OP_POP);
    chk("pop_under_dout", 32'(dout), 32'h11);
    chk("pop_under_err", 32'(err), 32'd1);
    do_op(1'b1, OP_NOP, 2'b00, '0, '0, '0, 1'b1);
    chk("err_clr", 32'(err), 32'd0);
    do_op(1'b1, OP_POP, 2'b00, '0, '0, '0, 1'b1);
    chk("err_clr_vs_new", 32'(err), 32'd1);
    do_op(1'b0, OP_NOP, 2'b00, '0, '0, '0, 1'b1);
    chk("err_clr_no_op", 32'(err), 32'd0);

    load_reg(8'hAA);
    simple(OP_PUSH);
    load_reg(8'h55);
    simple(OP_SWAP);
    chk("swap_dout", 32'(dout), 32'hAA);
    chk("swap_count", 32'(count), 32'd1);
    simple(OP_POP);
    chk("swap_pop_dout", 32'(dout), 32'h55);
    chk("swap_pop_count", 32'(count), 32'd0);

    do_op(1'b1, OP_LOAD, SEL_ALU, 8'h01, 8'hF0, '0, 1'b0);
    chk("load_alu", 32'(dout), 32'hF0);
    simple(OP_PUSH);
    simple(OP_CLR);
    chk("clr_dout", 32'(dout), 32'h00);
    chk("clr_zero", 32'(zero), 32'd1);
    chk("clr_count", 32'(count), 32'd1);
    simple(3'b111);
    chk("illegal_err", 32'(err), 32'd1);
    chk("illegal_count", 32'(count), 32'd1);
    simple(3'b110);
    chk("illegal6_dout", 32'(dout), 32'h00);
    do_op(1'b0, OP_LOAD, SEL_REG, 8'h99, '0, '0, 1'b0);
    chk("novalid_dout", 32'(dout), 32'h00);

    simple(OP_PUSH);
    simple(OP_PUSH);
    load_reg(8'h7E);
    chk("pre_rst_count", 32'(count), 32'd3);
    chk("pre_rst_err", 32'(err), 32'd1);
    #2;
    clb = 1'b1;
    #1;
    chk("async_dout", 32'(dout), 32'h0);
    chk("async_count", 32'(count), 32'h0);
    chk("async_err", 32'(err), 32'h0);
    chk("async_flags", {29'b0, zero, empty, full}, 32'b110);
    clb = 1'b0;
    simple(OP_POP);
    chk("post_rst_pop_err", 32'(err), 32'd1);
    chk("post_rst_pop_dout", 32'(dout), 32'h0);

    for (int n = 0; n < 400; n++) begin
      int r;
      logic [2:0] o;
      r = $urandom_range(0, 15);
      if (r < 2)       o = OP_NOP;
      else if (r < 5)  o = OP_LOAD;
      else if (r < 8)  o = OP_PUSH;
      else if (r < 11) o = OP_POP;
      else if (r < 13) o = OP_SWAP;
      else if (r < 14) o = OP_CLR;
      else if (r < 15) o = 3'(6 + $urandom_range(0, 1));
      else             o = OP_LOAD;
      do_op(($urandom_range(0, 4) != 0), o, 2'($urandom_range(0, 3)),
            8'($urandom), 8'($urandom), 4'($urandom),
            ($urandom_range(0, 7) == 0));
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/accum_stack.md
Name: accum_stack

Overview:
- Parametrised successor to the single 8-bit accumulator.
- Holds a WIDTH-bit accumulator fed from the register file, a zero-extended immediate or the ALU result.
- Adds a DEPTH-entry save stack (push/pop/swap), a clear op, status flags and a sticky error flag.
- Sits between the regfile/ALU and the control unit; dout drives the ALU A-operand and the regfile write-back.

Parameters:
- WIDTH, 8, accumulator and stack entry width in bits (≥ IMM_W).
- IMM_W, 4, immediate field width; zero-extended to WIDTH.
- DEPTH, 4, save-stack entries (≥ 2, any integer, not necessarily a power of 2).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- CLB  in  1  reset, asynchronous, active-high; clears all state.
- op_valid  in  1  qualifies op for this cycle.
- op  in  3  operation code (see Behaviour).
- sel_acc  in  2  LOAD source: 00 reg_in, 01 imm, 10 alu_in, 11 hold.
- imm  in  IMM_W  immediate operand.
- reg_in  in  WIDTH  register file operand.
- alu_in  in  WIDTH  ALU result.
- err_clr  in  1  clears sticky err.
- dout  out  WIDTH  accumulator value (registered).
- zero  out  1  dout == 0 (combinational from dout).
- count  out  $clog2(DEPTH+1)  stack occupancy (registered).
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- err  out  1  sticky error flag (registered).

Behaviour:
- Reset (CLB=1, any time, including mid-operation): dout=0, count=0, err=0. zero=1, empty=1, full=0. Stack storage is not cleared; it is unobservable while count=0.
- Single-cycle ops. The result is visible after the rising edge that samples op_valid=1. No stall and no handshake beyond op_valid.
- op_valid=0: all state holds. op is ignored.
- Op encodings:
  - 000 NOP: no change.
  - 001 LOAD: dout <= source per sel_acc. imm is zero-extended as {(WIDTH-IMM_W) zeros, imm}. sel_acc=11 means dout holds, no error.
  - 010 PUSH: stack[count] <= dout; count+1; dout unchanged. If full: no change, err set.
  - 011 POP: dout <= stack[count-1]; count-1. If empty: no change, err set.
  - 100 SWAP: dout <= stack[count-1]; stack[count-1] <= old dout; count unchanged. If empty: no change, err set.
  - 101 CLR: dout <= 0; count unchanged.
  - 110, 111: illegal. No state change, err set.
- Stack is LIFO over indices 0..DEPTH-1. No wrap-around; overflow and underflow are refused, never wrapped.
- err:
  - Set on any refused or illegal op.
  - Cleared by err_clr=1 only when the same cycle has no new error; a new error wins over clear.
  - err_clr does not block ops.
- Arithmetic: the block does none. The ALU result width equals WIDTH, so there is no truncation.

Decomposition:
- Shared package accum_pkg:
  - op encodings: OP_NOP, OP_LOAD, OP_PUSH, OP_POP, OP_SWAP, OP_CLR.
  - sel_acc encodings: SEL_REG, SEL_IMM, SEL_ALU, SEL_HOLD.
- Sub-module accum_lifo (parameters WIDTH, DEPTH):
  - Holds the storage array and count.
  - Inputs: push, pop, swap, wdata.
  - Outputs: top, count, full, empty.
- The top level holds dout, op decode, source mux and err.

Test Plan (WIDTH=8, IMM_W=4, DEPTH=4):
- Reset then LOAD sel=01 imm=4'hA → dout=8'h0A, zero=0. Next cycle LOAD sel=11 → dout stays 8'h0A, err=0.
- Set dout via LOAD reg_in=8'h11, then PUSH. Repeat with 8'h22, 8'h33, 8'h44 → count=4, full=1. Fifth PUSH → count stays 4, err=1. Four POPs → dout=8'h44, 8'h33, 8'h22, 8'h11; then empty=1.
- POP on empty → dout unchanged, err=1. err_clr=1 with NOP → err=0. Same cycle err_clr=1 + POP on empty → err stays 1.
- dout=8'h55, stack top=8'hAA. SWAP → dout=8'hAA. POP → dout=8'h55, count-1.
- LOAD sel=10 alu_in=8'hF0 then CLR → dout=8'h00, zero=1, count unchanged. op=3'b111 → no change, err=1. op_valid=0 with op=LOAD → dout holds.
- Assert CLB mid-sequence (count=3, dout=8'h7E, err=1) between edges → dout=0, count=0, err=0 immediately, without waiting for clk. After release, POP → err=1.
